// File: rtl/relu_result_writeback.sv
// relu_result_writeback
//   Captures one ReLU result word per dot-product unit on each tpu_done
//   pulse and writes them out one at a time, lowest active unit first, to
//   raster-ordered addresses starting at a programmable base. Pulses
//   layer_done once the programmed number of words has been written.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   start             begin a new layer (aborts any layer in progress)
//   out_base_addr     first write address, latched on start
//   num_outputs       words to write this layer, latched on start
//   active_units      unit mask sampled with tpu_done
//   tpu_done          relu_in valid for one cycle
//   relu_in           packed per-unit result words
//   wr_en/addr/data   write request to output memory
//   wr_ready          memory accepts the presented write this cycle
//   busy              block is not idle
//   layer_done        one-cycle pulse at layer completion
//   overflow          sticky: results arrived while still draining
module relu_result_writeback #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int NUM_UNITS    = 2,
  localparam int AW          = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [AW-1:0]                        out_base_addr,
  input  logic [AW:0]                          num_outputs,
  input  logic [NUM_UNITS-1:0]                 active_units,
  input  logic                                 tpu_done,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] relu_in,
  output logic                                 wr_en,
  output logic [AW-1:0]                        wr_addr,
  output logic [DATA_WIDTH-1:0]                wr_data,
  input  logic                                 wr_ready,
  output logic                                 busy,
  output logic                                 layer_done,
  output logic                                 overflow
);

  localparam int SW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                               state_q, state_d;
  logic [AW-1:0]                        base_q, base_d;
  logic [AW:0]                          total_q, total_d;
  logic [AW:0]                          written_q, written_d;
  logic [NUM_UNITS-1:0]                 pending_q, pending_d;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] hold_q, hold_d;
  logic                                 overflow_q, overflow_d;

  logic [SW-1:0]        sel;
  logic [NUM_UNITS-1:0] pending_clr;
  logic [AW:0]          written_inc;

  // Lowest set pending bit picks the unit to write next.
  always_comb begin
    sel = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = SW'(i);
    end
  end

  always_comb begin
    pending_clr      = pending_q;
    pending_clr[sel] = 1'b0;
  end

  assign written_inc = written_q + (AW+1)'(1);

  // Write port is a pure function of registered state; wr_ready only
  // affects the next state, never these outputs.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_q == S_DRAIN) begin
      wr_en   = 1'b1;
      wr_addr = base_q + written_q[AW-1:0];
      wr_data = hold_q[sel];
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign layer_done = (state_q == S_DONE);
  assign overflow   = overflow_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    total_d    = total_q;
    written_d  = written_q;
    pending_d  = pending_q;
    hold_d     = hold_q;
    overflow_d = overflow_q;

    // start has priority over everything, including a same-cycle tpu_done.
    if (start) begin
      base_d     = out_base_addr;
      total_d    = num_outputs;
      written_d  = '0;
      pending_d  = '0;
      overflow_d = 1'b0;
      state_d    = (num_outputs == '0) ? S_DONE : S_WAIT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // tpu_done while idle is silently ignored.
        end
        S_WAIT: begin
          if (tpu_done) begin
            hold_d    = relu_in;
            pending_d = active_units;
            if (active_units != '0) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (tpu_done) overflow_d = 1'b1;
          if (wr_ready) begin
            written_d = written_inc;
            pending_d = pending_clr;
            if (written_inc == total_q) begin
              // Layer complete: leftover results of this batch are dropped.
              pending_d = '0;
              state_d   = S_DONE;
            end else if (pending_clr == '0) begin
              state_d = S_WAIT;
            end
          end
        end
        S_DONE: begin
          if (tpu_done) overflow_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      total_q    <= '0;
      written_q  <= '0;
      pending_q  <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      total_q    <= total_d;
      written_q  <= written_d;
      pending_q  <= pending_d;
      hold_q     <= hold_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_relu_result_writeback.sv
module tb_relu_result_writeback;
  localparam int DW = 16;
  localparam int NU = 2;
  localparam int AW = 6;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [AW-1:0]          out_base_addr;
  logic [AW:0]            num_outputs;
  logic [NU-1:0]          active_units;
  logic                   tpu_done;
  logic [NU-1:0][DW-1:0]  relu_in;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [DW-1:0]          wr_data;
  logic                   wr_ready;
  logic                   busy;
  logic                   layer_done;
  logic                   overflow;

  relu_result_writeback #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .NUM_UNITS(NU)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .out_base_addr(out_base_addr),
    .num_outputs(num_outputs), .active_units(active_units), .tpu_done(tpu_done),
    .relu_in(relu_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .layer_done(layer_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ld_cnt = 0;
  int wen_cnt = 0;

  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];

  // Reference model state: a layer is just a base, a word budget and a
  // running count of words promised to memory.
  int m_base, m_total, m_count;

  // Pre-edge values at each rising edge describe what the memory accepted.
  always @(posedge clk) begin
    if (reset) begin
      if (wr_en && wr_ready) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
      end
      if (layer_done) ld_cnt++;
      if (wr_en) wen_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_addr.delete(); got_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic do_start(input int base, input int total);
    out_base_addr = AW'(base);
    num_outputs   = (AW+1)'(total);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_base = base; m_total = total; m_count = 0;
  endtask

  task automatic pulse(input logic [NU-1:0] mask, input logic [NU-1:0][DW-1:0] d);
    active_units = mask;
    relu_in      = d;
    tpu_done     = 1'b1;
    tick();
    tpu_done     = 1'b0;
  endtask

  // Words of a batch go out in unit order until the layer budget is used.
  task automatic model_accept(input logic [NU-1:0] mask, input logic [NU-1:0][DW-1:0] d);
    for (int i = 0; i < NU; i++) begin
      if (mask[i] && m_count < m_total) begin
        exp_addr.push_back(AW'((m_base + m_count) % (1 << AW)));
        exp_data.push_back(d[i]);
        m_count++;
      end
    end
  endtask

  task automatic wait_writes(input int n, input bit rnd);
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (got_addr.size() >= n) begin ok = 1'b1; break; end
      if (rnd) wr_ready = 1'($urandom_range(0, 1));
    end
    wr_ready = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_writes: got %0d writes, required %0d", got_addr.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; tpu_done = 1'b0; wr_ready = 1'b1;
    out_base_addr = '0; num_outputs = '0; active_units = '0; relu_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_en, busy, layer_done, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000", {wr_en, busy, layer_done, overflow});
    end
    checks++;
    if (wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_bus: got addr %0h data %0h required 0", wr_addr, wr_data);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy %b required 0", busy);
    end
  endtask

  task automatic test_basic();
    int ld0;
    clear_q();
    ld0 = ld_cnt;
    do_start(4, 4);
    pulse(2'b11, {16'hBBBB, 16'hAAAA});
    model_accept(2'b11, {16'hBBBB, 16'hAAAA});
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd4 || wr_data !== 16'hAAAA) begin
      errors++;
      $display("FAIL basic_latency: got en %b addr %0d data %h required 1 4 aaaa", wr_en, wr_addr, wr_data);
    end
    wait_writes(2, 1'b0);
    checks++;
    if (busy !== 1'b1 || wr_en !== 1'b0 || ld_cnt !== ld0) begin
      errors++;
      $display("FAIL basic_wait: got busy %b en %b ld %0d required 1 0 %0d", busy, wr_en, ld_cnt, ld0);
    end
    pulse(2'b11, {16'hDDDD, 16'hCCCC});
    model_accept(2'b11, {16'hDDDD, 16'hCCCC});
    wait_writes(4, 1'b0);
    checks++;
    if (layer_done !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: got layer_done %b required 1", layer_done);
    end
    checks++;
    if (got_addr.size() !== exp_addr.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d required %0d", got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL basic_word%0d: got (%0d,%h) required (%0d,%h)", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || layer_done !== 1'b0 || ld_cnt !== ld0 + 1) begin
      errors++;
      $display("FAIL basic_idle: got busy %b ld %b pulses %0d required 0 0 %0d", busy, layer_done, ld_cnt - ld0, 1);
    end
  endtask

  task automatic test_single_unit();
    clear_q();
    do_start(10, 8);
    pulse(2'b10, {16'h0033, 16'h0011});
    wait_writes(1, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (got_addr.size() !== 1 || got_addr[0] !== 6'd10 || got_data[0] !== 16'h0033) begin
      errors++;
      $display("FAIL single_word: got %0d writes first (%0d,%h) required 1 (10,0033)", got_addr.size(), got_addr[0], got_data[0]);
    end
    checks++;
    if (busy !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_wait: got busy %b en %b required 1 0", busy, wr_en);
    end
  endtask

  task automatic test_stall();
    int ld0;
    clear_q();
    ld0 = ld_cnt;
    do_start(20, 8);
    wr_ready = 1'b0;
    pulse(2'b01, {16'h1234, 16'h5678});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 6'd20 || wr_data !== 16'h5678) begin
        errors++;
        $display("FAIL stall_hold%0d: got en %b addr %0d data %h required 1 20 5678", k, wr_en, wr_addr, wr_data);
      end
    end
    wr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (got_addr.size() !== 1 || got_data[0] !== 16'h5678 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_one: got %0d writes en %b required 1 write en 0", got_addr.size(), wr_en);
    end
    checks++;
    if (ld_cnt !== ld0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses required 0", ld_cnt - ld0);
    end
  endtask

  task automatic test_wrap();
    clear_q();
    do_start(62, 3);
    pulse(2'b11, {16'hB002, 16'hA001});
    model_accept(2'b11, {16'hB002, 16'hA001});
    wait_writes(2, 1'b0);
    pulse(2'b11, {16'hD004, 16'hC003});
    model_accept(2'b11, {16'hD004, 16'hC003});
    wait_writes(3, 1'b0);
    checks++;
    if (layer_done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done: got layer_done %b required 1", layer_done);
    end
    for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL wrap_word%0d: got (%0d,%h) required (%0d,%h)", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_addr.size() !== 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_drop: got %0d writes busy %b required 3 0", got_addr.size(), busy);
    end
  endtask

  task automatic test_overflow();
    clear_q();
    do_start(0, 8);
    wr_ready = 1'b0;
    pulse(2'b11, {16'h2222, 16'h1111});
    model_accept(2'b11, {16'h2222, 16'h1111});
    pulse(2'b11, {16'h4444, 16'h3333});
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b required 1", overflow);
    end
    wr_ready = 1'b1;
    wait_writes(2, 1'b0);
    for (int i = 0; i < 2 && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL ovf_word%0d: got (%0d,%h) required (%0d,%h)", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b required 1", overflow);
    end
    do_start(0, 8);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b required 0", overflow);
    end
  endtask

  task automatic test_zero_and_reset();
    int ld0, w0;
    ld0 = ld_cnt; w0 = wen_cnt;
    do_start(5, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (ld_cnt !== ld0 + 1 || wen_cnt !== w0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_total: got pulses %0d wr_en cycles %0d busy %b required 1 0 0", ld_cnt - ld0, wen_cnt - w0, busy);
    end
    pulse(2'b11, {16'h7777, 16'h6666});
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b0 || wen_cnt !== w0) begin
      errors++;
      $display("FAIL idle_done_ignored: got ovf %b busy %b required 0 0", overflow, busy);
    end
    do_start(8, 8);
    wr_ready = 1'b0;
    pulse(2'b01, {16'h9999, 16'h8888});
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL async_reset: got en %b busy %b addr %0d data %h required 0 0 0 0", wr_en, busy, wr_addr, wr_data);
    end
    @(negedge clk);
    reset = 1'b1;
    wr_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_clean: got en %b busy %b required 0 0", wr_en, busy);
    end
  endtask

  task automatic test_random();
    for (int layer = 0; layer < 6; layer++) begin
      int ld0, guard;
      logic [NU-1:0] mask;
      logic [NU-1:0][DW-1:0] d;
      clear_q();
      ld0 = ld_cnt;
      do_start(int'($urandom_range(0, 63)), int'($urandom_range(1, 10)));
      guard = 0;
      while (m_count < m_total && guard < 40) begin
        mask = NU'($urandom_range(0, 3));
        for (int u = 0; u < NU; u++) d[u] = DW'($urandom);
        pulse(mask, d);
        model_accept(mask, d);
        wait_writes(exp_addr.size(), 1'b1);
        guard++;
      end
      @(negedge clk);
      checks++;
      if (ld_cnt !== ld0 + 1) begin
        errors++;
        $display("FAIL rand%0d_done: got %0d pulses required 1", layer, ld_cnt - ld0);
      end
      checks++;
      if (got_addr.size() !== exp_addr.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d required %0d", layer, got_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        checks++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL rand%0d_word%0d: got (%0d,%h) required (%0d,%h)", layer, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_unit();
    test_stall();
    test_wrap();
    test_overflow();
    test_zero_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
